// File: rtl/display_pkg.sv
// Shared display definitions: scanner state encoding and digit polarity helper.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_SHOW = 2'd2
  } scan_state_e;

  // Level that turns a digit off for the given select polarity.
  function automatic logic digit_off(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/scan_slot_counter.sv
// Slot timer for the display scanner: counts cycles within a digit slot and
// advances the digit index with wrap at the end of each slot.
module scan_slot_counter #(
  parameter int unsigned NumDigits  = 4,
  parameter int unsigned RefreshDiv = 8,
  parameter int unsigned DeadCycles = 2,
  parameter int unsigned CntW       = $clog2(RefreshDiv),
  parameter int unsigned IdxW       = (NumDigits > 1) ? $clog2(NumDigits) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            run_i,
  output logic            dead_end_o,
  output logic            slot_end_o,
  output logic            frame_end_o,
  output logic [IdxW-1:0] idx_o,
  output logic [IdxW-1:0] idx_next_o
);

  localparam logic [CntW-1:0] DeadLast = CntW'(DeadCycles - 1);
  localparam logic [CntW-1:0] SlotLast = CntW'(RefreshDiv - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumDigits - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;

  assign dead_end_o  = (cnt_q == DeadLast);
  assign slot_end_o  = (cnt_q == SlotLast);
  assign frame_end_o = slot_end_o && (idx_q == IdxLast);
  assign idx_o       = idx_q;
  assign idx_next_o  = idx_d;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (clear_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (run_i) begin
      if (slot_end_o) begin
        cnt_d = '0;
        idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Multi-digit 7-segment scanner: double-buffered frame, per-slot dead interval,
// leading-zero blanking and frame-aligned updates.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned REFRESH_DIV      = 50000,
  parameter int unsigned DEAD_CYCLES      = 16,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic                    i_blank_lz,
  output logic [3:0]              o_nibble,
  output logic [NUM_DIGITS-1:0]   o_digit_en,
  output logic                    o_pending,
  output logic                    o_frame_done
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic        Off  = digit_off(DIGIT_ACTIVE_LOW);

  typedef logic [NUM_DIGITS-1:0][3:0] frame_t;

  scan_state_e           state_q, state_d;
  frame_t                disp_buf_q, disp_buf_d, pend_buf_q, pend_buf_d;
  logic                  pending_q, pending_d;
  logic [3:0]            nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d, lz_zero;
  logic                  blank_q, blank_d, frame_done_q, frame_done_d;
  logic                  dead_end, slot_end, frame_end, boundary, slot_start;
  logic [IdxW-1:0]       idx, idx_next;

  scan_slot_counter #(
    .NumDigits (NUM_DIGITS),
    .RefreshDiv(REFRESH_DIV),
    .DeadCycles(DEAD_CYCLES)
  ) u_counter (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .clear_i    (!i_enable || (state_q == ST_IDLE)),
    .run_i      (state_q != ST_IDLE),
    .dead_end_o (dead_end),
    .slot_end_o (slot_end),
    .frame_end_o(frame_end),
    .idx_o      (idx),
    .idx_next_o (idx_next)
  );

  assign boundary = i_enable && (state_q == ST_SHOW) && frame_end;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_enable) state_d = ST_DEAD;
      ST_DEAD: if (dead_end) state_d = ST_SHOW;
      ST_SHOW: if (slot_end) state_d = ST_DEAD;
      default: state_d = ST_IDLE;
    endcase
    if (!i_enable) state_d = ST_IDLE;
  end

  // Idle loads go straight to the display; running loads wait for the boundary.
  always_comb begin
    disp_buf_d = disp_buf_q;
    pend_buf_d = pend_buf_q;
    pending_d  = pending_q;
    if (state_q == ST_IDLE) begin
      if (i_load) begin
        disp_buf_d = frame_t'(i_value);
        pending_d  = 1'b0;
      end
    end else if (boundary) begin
      if (i_load) begin
        disp_buf_d = frame_t'(i_value);
        pending_d  = 1'b0;
      end else if (pending_q) begin
        disp_buf_d = pend_buf_q;
        pending_d  = 1'b0;
      end
    end else if (i_load) begin
      pend_buf_d = frame_t'(i_value);
      pending_d  = 1'b1;
    end
  end

  // lz_zero[k]: nibbles k..NUM_DIGITS-1 of the next frame are all zero.
  always_comb begin
    logic acc;
    acc     = 1'b1;
    lz_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc        = acc && (disp_buf_d[k] == 4'h0);
      lz_zero[k] = acc;
    end
  end

  // Nibble and blanking are latched once per slot, on entry to the dead interval.
  always_comb begin
    slot_start   = (state_d == ST_DEAD) && (state_q != ST_DEAD);
    nibble_d     = nibble_q;
    blank_d      = blank_q;
    frame_done_d = boundary;
    if (slot_start) begin
      nibble_d = disp_buf_d[idx_next];
      blank_d  = i_blank_lz && (idx_next != '0) && lz_zero[idx_next];
    end
    digit_en_d = {NUM_DIGITS{Off}};
    if ((state_d == ST_SHOW) && !blank_d) digit_en_d[idx] = ~Off;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      disp_buf_q   <= '0;
      pend_buf_q   <= '0;
      pending_q    <= 1'b0;
      nibble_q     <= 4'h0;
      blank_q      <= 1'b0;
      digit_en_q   <= {NUM_DIGITS{Off}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      disp_buf_q   <= disp_buf_d;
      pend_buf_q   <= pend_buf_d;
      pending_q    <= pending_d;
      nibble_q     <= nibble_d;
      blank_q      <= blank_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_nibble     = nibble_q;
  assign o_digit_en   = digit_en_q;
  assign o_pending    = pending_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: directed scenarios plus random traffic, checked
// every cycle against a time-based reference model of the scan schedule.
module tb_display_scan_mux;

  localparam int N = 4;
  localparam int R = 8;
  localparam int D = 2;

  logic          clk, rst_n, enable, load, blank_lz;
  logic [4*N-1:0] value;
  logic [3:0]    o_nibble;
  logic [N-1:0]  o_digit_en;
  logic          o_pending, o_frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time since scanning started, buffers as plain words.
  bit        m_run, m_pending, m_fd, m_blank;
  int        m_t;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_nib;

  display_scan_mux #(
    .NUM_DIGITS      (N),
    .REFRESH_DIV     (R),
    .DEAD_CYCLES     (D),
    .DIGIT_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_value     (value),
    .i_load      (load),
    .i_blank_lz  (blank_lz),
    .o_nibble    (o_nibble),
    .o_digit_en  (o_digit_en),
    .o_pending   (o_pending),
    .o_frame_done(o_frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pending = 0; m_fd = 0; m_blank = 0;
    m_t = 0; m_disp = '0; m_pend = '0; m_nib = '0;
  endtask

  task automatic model_edge();
    bit bnd;
    int dg;
    bnd = m_run && enable && (m_t == N*R - 1);
    if (!m_run) begin
      if (load) begin m_disp = value; m_pending = 0; end
    end else if (bnd) begin
      if (load) begin m_disp = value; m_pending = 0; end
      else if (m_pending) begin m_disp = m_pend; m_pending = 0; end
    end else if (load) begin
      m_pend = value; m_pending = 1;
    end
    m_fd = bnd;
    if (!enable) begin m_run = 0; m_t = 0; end
    else if (!m_run) begin m_run = 1; m_t = 0; end
    else m_t = (m_t + 1) % (N*R);
    if (m_run && (m_t % R == 0)) begin
      dg      = m_t / R;
      m_nib   = m_disp[4*dg +: 4];
      m_blank = blank_lz && (dg != 0) && ((m_disp >> (4*dg)) == 16'h0);
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] e;
    e = '1;
    if (m_run && (m_t % R) >= D && !m_blank) e[m_t / R] = 1'b0;
    check("digit_en", 32'(o_digit_en), 32'(e));
    check("nibble", 32'(o_nibble), 32'(m_nib));
    check("pending", 32'(o_pending), 32'(m_pending));
    check("frame_done", 32'(o_frame_done), 32'(m_fd));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic wait_t(input int target);
    bit hit;
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_run && m_t == target) begin hit = 1; break; end
      step();
    end
    if (!hit) check("wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"}, 32'(o_digit_en), 32'hF);
    check({tag, "_nib"}, 32'(o_nibble), 32'h0);
    check({tag, "_pend"}, 32'(o_pending), 32'h0);
    check({tag, "_fd"}, 32'(o_frame_done), 32'h0);
  endtask

  initial begin
    int fd_cnt;
    rst_n = 1'b1; enable = 0; load = 0; blank_lz = 0; value = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #11 check_reset_outputs("reset");
    #1 rst_n = 1'b1;

    // Idle load goes straight to the display, then scanning starts.
    value = 16'h1234; load = 1;
    step();
    load = 0; enable = 1;
    step(); step(); step();
    check("first_on_en", 32'(o_digit_en), 32'hE);
    check("first_on_nib", 32'(o_nibble), 32'h4);
    fd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (o_frame_done) fd_cnt++;
    end
    check("fd_per_frame", 32'(fd_cnt), 32'd1);

    // Mid-frame load waits for the boundary.
    wait_t(5);
    value = 16'hABCD; load = 1;
    step();
    load = 0;
    check("pend_set", 32'(o_pending), 32'h1);
    wait_t(31);
    step();
    check("new_frame_nib", 32'(o_nibble), 32'hD);
    check("pend_clr", 32'(o_pending), 32'h0);

    // Load exactly on the boundary cycle bypasses the pending stage.
    wait_t(31);
    value = 16'h00F0; load = 1;
    step();
    load = 0;
    check("bnd_load_nib0", 32'(o_nibble), 32'h0);
    check("bnd_load_pend", 32'(o_pending), 32'h0);
    wait_t(8);
    check("bnd_load_nib1", 32'(o_nibble), 32'hF);

    // Leading-zero blanking.
    wait_t(31);
    value = 16'h0007; load = 1; blank_lz = 1;
    step();
    load = 0;
    wait_t(10);
    check("lz_digit1_off", 32'(o_digit_en), 32'hF);
    wait_t(2);
    check("lz_digit0_on", 32'(o_digit_en), 32'hE);
    wait_t(31);
    value = 16'h0000; load = 1;
    step();
    load = 0;
    wait_t(2);
    check("zero_digit0_en", 32'(o_digit_en), 32'hE);
    check("zero_digit0_nib", 32'(o_nibble), 32'h0);
    blank_lz = 0;
    wait_t(10);
    check("nolz_digit1_on", 32'(o_digit_en), 32'hD);

    // Drop enable during digit 2's on time, then restart.
    wait_t(19);
    enable = 0;
    step();
    check("disable_off", 32'(o_digit_en), 32'hF);
    enable = 1;
    step(); step();
    check("restart_dead", 32'(o_digit_en), 32'hF);
    step();
    check("restart_on", 32'(o_digit_en), 32'hE);

    // Asynchronous reset between clock edges.
    wait_t(31);
    value = 16'h9876; load = 1;
    step();
    load = 0;
    wait_t(12);
    check("pre_reset_nib", 32'(o_nibble), 32'h7);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    #1 rst_n = 1'b1;
    step();
    check("post_reset_nib", 32'(o_nibble), 32'h0);

    // Random traffic.
    for (int c = 0; c < 2500; c++) begin
      if (enable) enable = ($urandom_range(0, 199) != 0);
      else enable = ($urandom_range(0, 3) == 0);
      load  = ($urandom_range(0, 15) == 0);
      value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Time-multiplexing scanner for a multi-digit 7-segment display. Holds a frame buffer of NUM_DIGITS hex nibbles and presents one nibble at a time on o_nibble to the downstream hex-to-7-segment decoder. It drives the matching digit-select line and inserts a dead interval between digits to prevent ghosting. It sits between the adder result and the segment decoder; new values are taken in only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- NUM_DIGITS, 4: digit count, 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be greater than DEAD_CYCLES.
- DEAD_CYCLES, 16: cycles at the start of each slot with all digits off; ≥1.
- DIGIT_ACTIVE_LOW, 1: 1 means a digit is on when its o_digit_en bit is 0.
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  scanning enable; low blanks all digits.
- i_value  in  4*NUM_DIGITS  new display value; nibble k is digit k, and digit 0 is least significant.
- i_load  in  1  single-cycle strobe that captures i_value.
- i_blank_lz  in  1  leading-zero blanking enable, sampled each slot.
- o_nibble  out  4  nibble for the decoder's 4-bit input, registered.
- o_digit_en  out  NUM_DIGITS  digit select, one-hot-active, registered.
- o_pending  out  1  a captured value is waiting for the next frame boundary.
- o_frame_done  out  1  one-cycle pulse when the last digit's slot ends.

## Operation
- Registers:
  - pend_buf: the captured value waiting for display.
  - disp_buf: the frame currently shown.
  - digit index idx, 0..NUM_DIGITS-1.
  - slot counter cnt, 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV).
  - state.
- States:
  - IDLE: all digits off. Moves to DEAD with idx=0, cnt=0 when i_enable=1.
  - DEAD: all digits off, and o_nibble = disp_buf[idx]. Moves to SHOW when cnt = DEAD_CYCLES-1.
  - SHOW: digit idx on unless it is blanked. When cnt = REFRESH_DIV-1: cnt←0, idx←idx+1 with wrap to 0, next state DEAD.
- i_enable=0 in any state: IDLE on the next edge, all digits off, and cnt and idx cleared. pend_buf and disp_buf are kept.
- Load:
  - i_load=1 sets pend_buf←i_value and o_pending←1.
  - A later i_load before the boundary overwrites pend_buf; the last load wins.
- Frame boundary is the SHOW cycle where idx = NUM_DIGITS-1 and cnt = REFRESH_DIV-1. On it:
  - If o_pending is set, disp_buf←pend_buf and o_pending←0.
  - If i_load is asserted in the same cycle, disp_buf←i_value directly and o_pending stays 0.
  - o_frame_done pulses in the following cycle.
- Loads while in IDLE: disp_buf←i_value immediately, with no pending stage.
- Leading-zero blanking:
  - Digit k (k≥1) is blanked when i_blank_lz=1 and every nibble k..NUM_DIGITS-1 of disp_buf is 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps its select inactive throughout SHOW; o_nibble still updates.
- Polarity: digit "off" is 1 when DIGIT_ACTIVE_LOW=1 and 0 otherwise.

## Timing
- Reset values:
  - o_digit_en all off (all 1s for the default).
  - o_nibble=0, o_pending=0, o_frame_done=0.
  - state=IDLE, idx=0, cnt=0.
  - pend_buf=0, disp_buf=0.
- o_nibble changes only on the first DEAD cycle of a slot. It is stable for DEAD_CYCLES cycles before the digit select turns on, which covers decoder settling.
- Slot length is exactly REFRESH_DIV cycles: DEAD_CYCLES off, then REFRESH_DIV-DEAD_CYCLES on.
- Frame length is NUM_DIGITS*REFRESH_DIV cycles.
- Latency from i_enable rising to the first digit on: 1 + DEAD_CYCLES cycles.
- Latency from i_enable falling to all digits off: 1 cycle.
- Latency from i_load to display: at most one frame plus one slot.
- Reset asserted mid-frame: outputs go to reset values immediately, independent of i_clk.

## Structure
- Shared package display_pkg holds:
  - the state encoding constants ST_IDLE, ST_DEAD, ST_SHOW;
  - a digit_off(polarity) constant function, also used by other display blocks.
- Sub-module scan_slot_counter contains cnt, the dead-end and slot-end compares, and the idx wrap. It outputs dead_end, slot_end, frame_end and idx.
- The top level holds the buffers, the FSM, the blanking logic and the output registers.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, DIGIT_ACTIVE_LOW=1.
- Reset, then i_enable=1, load 16'h1234: o_nibble sequence 4,3,2,1; o_digit_en 1110, 1101, 1011, 0111, each low for 6 cycles after 2 cycles of 1111; o_frame_done pulses every 32 cycles.
- Load 16'hABCD mid-frame: o_pending=1 until the boundary; the old frame completes intact; the next frame shows D,C,B,A.
- i_load asserted exactly on the boundary cycle with 16'h00F0: that value is shown in the next frame and o_pending never rises.
- Display 16'h0007 with i_blank_lz=1: only digit 0 selects. Display 16'h0000: digit 0 shows 0. Toggle i_blank_lz=0: all four digits select.
- Drop i_enable in SHOW of digit 2: o_digit_en=1111 the next cycle. Re-enable: restart at digit 0 after 2 dead cycles.
- Assert i_rst_n=0 mid-SHOW between clock edges: outputs reach reset values without a clock edge; disp_buf is cleared.
